// File: rtl/iram_load_ctrl.sv
// Instruction-memory arbiter: passes CPU fetches through in RUN, and loads a
// framed byte stream (count, hi/lo data bytes, XOR checksum) while the CPU is stalled.
module iram_load_ctrl #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic [7:0]    CPU_ADDR,
   output logic [15:0]   CPU_Q,
   output logic          CPU_STALL,
   output logic          CPU_RST,
   input  logic          LD_START,
   input  logic          LD_VALID,
   input  logic [7:0]    LD_BYTE,
   output logic          LD_READY,
   output logic          LD_DONE,
   output logic          LD_ERR,
   output logic [7:0]    LD_COUNT,
   output logic [AW-1:0] MEM_RADDR,
   input  logic [15:0]   MEM_RDATA,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_WADDR,
   output logic [15:0]   MEM_WDATA
);

   // state | meaning
   // RUN   | CPU owns memory, fetches pass through
   // HDR   | waiting for word-count byte
   // HI    | waiting for high data byte
   // LO    | waiting for low data byte
   // WR    | one-cycle memory write of assembled word
   // CHK   | waiting for checksum byte
   // ERR   | frame rejected, CPU held until next LD_START
   typedef enum logic [2:0] {
      S_RUN, S_HDR, S_HI, S_LO, S_WR, S_CHK, S_ERR
   } state_t;

   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   state_t        state, state_nxt;
   logic [7:0]    n_q, hi_q, csum_q, idx_q, count_q;
   logic [AW-1:0] waddr_q;
   logic [15:0]   wdata_q;
   logic          done_q, err_q;
   logic          xfer, hdr_bad, last_word, csum_ok;
   logic          unused_addr_lsb;

   assign xfer      = LD_VALID & LD_READY;
   assign hdr_bad   = (LD_BYTE == 8'd0) || ({1'b0, LD_BYTE} > DEPTH_L);
   assign last_word = (idx_q == n_q - 8'd1);
   assign csum_ok   = (LD_BYTE == csum_q);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_RUN:   if (LD_START) state_nxt = S_HDR;
         S_HDR:   if (xfer) state_nxt = hdr_bad ? S_ERR : S_HI;
         S_HI:    if (xfer) state_nxt = S_LO;
         S_LO:    if (xfer) state_nxt = S_WR;
         S_WR:    state_nxt = last_word ? S_CHK : S_HI;
         S_CHK:   if (xfer) state_nxt = csum_ok ? S_RUN : S_ERR;
         S_ERR:   if (LD_START) state_nxt = S_HDR;
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_RUN;
         n_q     <= '0;
         hi_q    <= '0;
         csum_q  <= '0;
         idx_q   <= '0;
         count_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == S_CHK) && xfer && csum_ok;
         if (state_nxt == S_ERR && state != S_ERR)
            err_q <= 1'b1;
         unique case (state)
            S_RUN, S_ERR: begin
               if (LD_START) begin
                  err_q   <= 1'b0;
                  count_q <= '0;
                  idx_q   <= '0;
                  csum_q  <= '0;
               end
            end
            S_HDR: if (xfer) n_q <= LD_BYTE;
            S_HI: begin
               if (xfer) begin
                  hi_q   <= LD_BYTE;
                  csum_q <= csum_q ^ LD_BYTE;
               end
            end
            S_LO: begin
               if (xfer) begin
                  csum_q  <= csum_q ^ LD_BYTE;
                  wdata_q <= {hi_q, LD_BYTE};
                  waddr_q <= idx_q[AW-1:0];
               end
            end
            S_WR: begin
               idx_q   <= idx_q + 8'd1;
               count_q <= count_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Ready is a pure decode of the registered state, so it never depends on LD_VALID.
   assign LD_READY  = (state == S_HDR) || (state == S_HI) ||
                      (state == S_LO)  || (state == S_CHK);
   assign CPU_STALL = (state != S_RUN);
   assign CPU_Q     = (state == S_RUN) ? MEM_RDATA : 16'h0000;
   assign CPU_RST   = done_q;
   assign LD_DONE   = done_q;
   assign LD_ERR    = err_q;
   assign LD_COUNT  = count_q;
   assign MEM_RADDR = CPU_ADDR[AW:1];
   assign MEM_WE    = (state == S_WR);
   assign MEM_WADDR = waddr_q;
   assign MEM_WDATA = wdata_q;

   assign unused_addr_lsb = CPU_ADDR[0];

endmodule

// File: tb/tb_iram_load_ctrl.sv
// Directed bench for iram_load_ctrl: frame-level model predicts writes and outcome,
// a per-cycle monitor checks fetch path and write stream against it.
module tb_iram_load_ctrl;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [7:0]  CPU_ADDR = 8'h00;
   logic [15:0] CPU_Q;
   logic        CPU_STALL, CPU_RST;
   logic        LD_START = 1'b0, LD_VALID = 1'b0;
   logic [7:0]  LD_BYTE = 8'h00;
   logic        LD_READY, LD_DONE, LD_ERR;
   logic [7:0]  LD_COUNT;
   logic [6:0]  MEM_RADDR, MEM_WADDR;
   logic [15:0] MEM_RDATA, MEM_WDATA;
   logic        MEM_WE;

   iram_load_ctrl #(.DEPTH(128), .AW(7)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CPU_ADDR(CPU_ADDR), .CPU_Q(CPU_Q),
      .CPU_STALL(CPU_STALL), .CPU_RST(CPU_RST), .LD_START(LD_START),
      .LD_VALID(LD_VALID), .LD_BYTE(LD_BYTE), .LD_READY(LD_READY),
      .LD_DONE(LD_DONE), .LD_ERR(LD_ERR), .LD_COUNT(LD_COUNT),
      .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA), .MEM_WE(MEM_WE),
      .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA)
   );

   always #5 CLK = ~CLK;

   logic [15:0] mem [128];
   assign MEM_RDATA = mem[MEM_RADDR];
   always @(posedge CLK) if (MEM_WE) mem[MEM_WADDR] <= MEM_WDATA;

   int cmp_n = 0;
   int bad_n = 0;
   int done_cnt = 0;
   logic [22:0] wq[$];
   logic [7:0]  fb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Per-cycle monitor: fetch path, pulse pairing and the expected write stream.
   always @(negedge CLK) begin
      if (RESET_N) begin
         chk("raddr", 32'(MEM_RADDR), 32'(CPU_ADDR[7:1]));
         chk("cpu_q", 32'(CPU_Q), CPU_STALL ? 32'h0 : 32'(mem[CPU_ADDR[7:1]]));
         chk("rst_eq_done", 32'(CPU_RST), 32'(LD_DONE));
         chk("ready_implies_stall", 32'(LD_READY & ~CPU_STALL), 32'h0);
         if (LD_DONE) done_cnt++;
         if (MEM_WE) begin
            chk("ready_low_in_wr", 32'(LD_READY), 32'h0);
            if (wq.size() == 0) begin
               cmp_n++;
               bad_n++;
               $display("FAIL unexpected_we actual=addr %0h data %0h required=no write",
                        MEM_WADDR, MEM_WDATA);
            end else begin
               logic [22:0] e;
               e = wq.pop_front();
               chk("wr_addr", 32'(MEM_WADDR), 32'(e[22:16]));
               chk("wr_data", 32'(MEM_WDATA), 32'(e[15:0]));
            end
         end
      end
   end

   task automatic load(input logic [63:0] v, input int len);
      fb.delete();
      for (int i = 0; i < len; i++) fb.push_back(v[8*(len-1-i) +: 8]);
   endtask

   task automatic send_byte(input logic [7:0] v);
      bit ok;
      ok = 1'b0;
      LD_VALID = 1'b1;
      LD_BYTE  = v;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge CLK);
         if (LD_READY) ok = 1'b1;
         @(posedge CLK);
      end
      #1;
      if (!ok) begin
         cmp_n++;
         bad_n++;
         $display("FAIL byte_accept actual=timeout required=accepted byte %0h", v);
      end
   endtask

   task automatic start_pulse();
      LD_START = 1'b1;
      @(posedge CLK); #1;
      LD_START = 1'b0;
      chk("stall_after_start", 32'(CPU_STALL), 32'h1);
      chk("err_cleared_on_start", 32'(LD_ERR), 32'h0);
   endtask

   // Frame model: derive writes, checksum verdict and final status from fb.
   task automatic frame(input string tag, input bit hold);
      int n, nsend, d0;
      bit hdr_bad, good;
      logic [7:0] cs;
      logic [15:0] ew[$];
      n = int'(fb[0]);
      hdr_bad = (n == 0) || (n > 128);
      good = 1'b0;
      cs = 8'h00;
      if (!hdr_bad) begin
         for (int i = 0; i < n; i++) begin
            ew.push_back({fb[1+2*i], fb[2+2*i]});
            wq.push_back({7'(i), fb[1+2*i], fb[2+2*i]});
            cs = cs ^ fb[1+2*i] ^ fb[2+2*i];
         end
         good = (fb[2*n+1] == cs);
      end
      nsend = hdr_bad ? 1 : 2*n + 2;
      d0 = done_cnt;
      chk({tag, " idle_before"}, 32'(CPU_STALL & ~LD_ERR), 32'h0);
      start_pulse();
      for (int i = 0; i < nsend; i++) begin
         send_byte(fb[i]);
         if (!hold) begin
            LD_VALID = 1'b0;
            @(posedge CLK); #1;
         end
      end
      LD_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk({tag, " writes_drained"}, 32'(wq.size()), 32'h0);
      chk({tag, " done_pulses"}, 32'(done_cnt - d0), good ? 32'h1 : 32'h0);
      chk({tag, " ld_err"}, 32'(LD_ERR), good ? 32'h0 : 32'h1);
      chk({tag, " ld_count"}, 32'(LD_COUNT), hdr_bad ? 32'h0 : 32'(n));
      chk({tag, " stall"}, 32'(CPU_STALL), good ? 32'h0 : 32'h1);
      for (int i = 0; i < ew.size(); i++)
         chk({tag, " mem_word"}, 32'(mem[i]), 32'(ew[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'hA500 | 16'(i);

      #12;
      chk("rst stall", 32'(CPU_STALL), 32'h0);
      chk("rst ready", 32'(LD_READY), 32'h0);
      chk("rst done", 32'(LD_DONE), 32'h0);
      chk("rst cpu_rst", 32'(CPU_RST), 32'h0);
      chk("rst err", 32'(LD_ERR), 32'h0);
      chk("rst we", 32'(MEM_WE), 32'h0);
      chk("rst count", 32'(LD_COUNT), 32'h0);
      chk("rst waddr", 32'(MEM_WADDR), 32'h0);
      chk("rst wdata", 32'(MEM_WDATA), 32'h0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      @(posedge CLK); #1;

      load(64'h02F001F49194, 6);
      frame("good", 1'b0);
      chk("good lit mem0", 32'(mem[0]), 32'hF001);
      chk("good lit mem1", 32'(mem[1]), 32'hF491);
      chk("good lit count", 32'(LD_COUNT), 32'h2);

      load(64'h02F001F49194, 6);
      frame("backpressure", 1'b1);

      load(64'h00, 1);
      frame("hdr_zero", 1'b0);
      chk("hdr_zero lit err", 32'(LD_ERR), 32'h1);
      load(64'h02F001F49194, 6);
      frame("after_zero", 1'b0);

      load(64'h81, 1);
      frame("hdr_129", 1'b0);
      load(64'h02F001F49194, 6);
      frame("after_129", 1'b0);

      load(64'h01123400, 4);
      frame("bad_csum", 1'b0);
      chk("bad_csum lit mem0", 32'(mem[0]), 32'h1234);
      chk("bad_csum lit count", 32'(LD_COUNT), 32'h1);

      load(64'h02F001F49194, 6);
      frame("recover", 1'b0);

      // Reset mid-frame, just after word 1's high byte.
      wq.push_back({7'd0, 16'hF001});
      start_pulse();
      send_byte(8'h02);
      send_byte(8'hF0);
      send_byte(8'h01);
      send_byte(8'hF4);
      LD_VALID = 1'b0;
      CPU_ADDR = 8'h0C;
      #2;
      RESET_N = 1'b0;
      #1;
      chk("abort stall", 32'(CPU_STALL), 32'h0);
      chk("abort ready", 32'(LD_READY), 32'h0);
      chk("abort done", 32'(LD_DONE), 32'h0);
      chk("abort cpu_rst", 32'(CPU_RST), 32'h0);
      chk("abort we", 32'(MEM_WE), 32'h0);
      chk("abort count", 32'(LD_COUNT), 32'h0);
      chk("abort wdata", 32'(MEM_WDATA), 32'h0);
      chk("abort raddr", 32'(MEM_RADDR), 32'h6);
      chk("abort cpu_q", 32'(CPU_Q), 32'hA506);
      chk("abort writes_drained", 32'(wq.size()), 32'h0);
      chk("abort lit mem0", 32'(mem[0]), 32'hF001);
      chk("abort lit mem1", 32'(mem[1]), 32'hF491);
      @(posedge CLK); #1;
      RESET_N = 1'b1;

      for (int a = 0; a < 3; a++) begin
         logic [15:0] lit [3];
         lit[0] = 16'hF001;
         lit[1] = 16'hF491;
         lit[2] = 16'hA502;
         @(posedge CLK); #1;
         CPU_ADDR = 8'(2*a);
         @(negedge CLK);
         chk("pass raddr", 32'(MEM_RADDR), 32'(a));
         chk("pass cpu_q", 32'(CPU_Q), 32'(lit[a]));
         chk("pass stall", 32'(CPU_STALL), 32'h0);
      end
      chk("no stray done", 32'(LD_DONE), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
      $finish;
   end

endmodule

// File: doc/iram_load_ctrl.md
Name: iram_load_ctrl

Overview:
- Shares the 128x16 instruction memory between the processor's fetch port and a byte-wide program-load port.
- In RUN it passes fetch reads straight through.
- On LD_START it stalls the CPU and accepts a framed byte stream: count, data words high byte first, then an XOR checksum. It writes each word into instruction memory, then releases the CPU with a one-cycle restart pulse.
- Lets heart-rate-monitor programs be reloaded without re-synthesising the ROM image.

Parameters:
- DEPTH, 128, instruction memory depth in 16-bit words.
- AW, 7, word-address width; equals log2(DEPTH).

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous active-low reset
- CPU_ADDR  in  8  CPU byte fetch address; word index = CPU_ADDR[7:1]
- CPU_Q  out  16  instruction to CPU
- CPU_STALL  out  1  CPU must hold PC and suppress writes
- CPU_RST  out  1  one-cycle request to restart CPU at PC=0
- LD_START  in  1  begin a load frame (level sampled per cycle)
- LD_VALID  in  1  LD_BYTE valid
- LD_BYTE  in  8  load stream byte
- LD_READY  out  1  controller accepts byte this cycle
- LD_DONE  out  1  one-cycle pulse, frame loaded with good checksum
- LD_ERR  out  1  sticky frame error
- LD_COUNT  out  8  words written in current/last frame
- MEM_RADDR  out  AW  memory read address (combinational read)
- MEM_RDATA  in  16  memory read data
- MEM_WE  out  1  memory write enable, one cycle per word
- MEM_WADDR  out  AW  memory write address
- MEM_WDATA  out  16  memory write data

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - State goes to RUN.
  - CPU_STALL, CPU_RST, LD_READY, LD_DONE, LD_ERR, MEM_WE = 0.
  - LD_COUNT, idx, csum, N, hi = 0; MEM_WADDR/MEM_WDATA = 0.
  - Memory contents are untouched; a partial load persists.
- Byte transfer occurs on a rising edge with LD_VALID & LD_READY. LD_READY is registered by state: 1 in HDR/HI/LO/CHK, 0 elsewhere. Unaccepted bytes must be held by the sender.
- MEM_RADDR = CPU_ADDR[7:1] in all states.
- CPU_Q = MEM_RDATA in RUN, otherwise 16'h0000.
- CPU_STALL = 1 in every state except RUN.
- States and transitions:
  - RUN: LD_START=1 -> HDR; clear LD_ERR, LD_COUNT, idx, csum. Stall rises the cycle after LD_START is sampled.
  - HDR: on transfer, N <= LD_BYTE. If N==0 or N>DEPTH -> ERR, else -> HI.
  - HI: on transfer, hi <= byte, csum ^= byte -> LO.
  - LO: on transfer, csum ^= byte; MEM_WDATA <= {hi,byte}; MEM_WADDR <= idx -> WR.
  - WR: MEM_WE=1 for exactly this cycle; idx++ and LD_COUNT++. If idx==N-1 -> CHK, else -> HI.
  - CHK: on transfer, byte==csum -> RUN, with LD_DONE=1 and CPU_RST=1 on the first RUN cycle. Mismatch -> ERR.
  - ERR: LD_ERR=1, stall held, no writes. LD_START -> HDR (clears LD_ERR); otherwise stay.
- LD_START in HDR/HI/LO/WR/CHK is ignored; no restart mid-frame.
- N is not part of the checksum. csum is an 8-bit XOR of all 2N data bytes.
- Word writes land at addresses 0..N-1 in order. Words are never written beyond N-1.
- RESET_N falling mid-frame aborts immediately to RUN with no LD_DONE and no CPU_RST. Reset of the CPU itself is the system's job.

Test Plan:
- Good frame: RUN, LD_START, then bytes 02,F0,01,F4,91,94.
  - Required: MEM_WE pulses at addr 0 data F001, then addr 1 data F491.
  - Then LD_DONE=1 and CPU_RST=1 for one cycle, LD_COUNT=2, LD_ERR=0, stall drops.
- Backpressure: same frame with LD_VALID held high continuously.
  - LD_READY=0 during each WR cycle; no byte lost or duplicated; same writes as the good frame.
- Bad header: bytes 00, and separately 81 (129).
  - Required: ERR, LD_ERR=1, no MEM_WE, stall stays high.
  - A following LD_START with a good frame clears LD_ERR and completes.
- Checksum mismatch: 01,12,34, then 00 (expected 26).
  - Word 1234 written at addr 0; LD_ERR=1, no LD_DONE, no CPU_RST, stall held.
- Reset mid-load: drop RESET_N after the HI byte of word 1.
  - All outputs 0 asynchronously, state RUN; CPU_Q follows MEM_RDATA for CPU_ADDR=0x0C (word 6).
- Passthrough: RUN with CPU_ADDR stepping 0x00, 0x02, 0x04.
  - MEM_RADDR = 0, 1, 2; CPU_Q = MEM_RDATA each cycle; CPU_STALL = 0 throughout.
